serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial N-bit subtractor computing DIFF = A - B, one bit per clock, LSB first.
//   It is the subtract-direction counterpart of the lab adder blocks and reuses the half-cell style:
//   two half_subtractor cells plus a borrow flip-flop form the per-bit full subtractor.
//   It sits beside the adder datapath as the sequential ALU subtract unit, with a START/DONE handshake.
// PARAMETERS
//   WIDTH   8   operand and result width in bits; must be >= 2
// PORTS
//   CLK     in   1      single system clock, rising edge
//   RST     in   1      synchronous reset, active-high
//   START   in   1      request; sampled only in IDLE
//   A       in   WIDTH  minuend, captured on the accepted START edge
//   B       in   WIDTH  subtrahend, captured on the accepted START edge
//   BUSY    out  1      high while bits are being shifted (SHIFT state)
//   DONE    out  1      one-cycle pulse: result valid
//   DIFF    out  WIDTH  A - B modulo 2^WIDTH; held until the next accepted START
//   BORROW  out  1      final borrow out (1 when A < B unsigned)
//   OVF     out  1      two's-complement overflow of A - B
// BEHAVIOUR
//   - Reset (RST=1 at a CLK edge) takes priority over everything: state=IDLE; BUSY, DONE, DIFF, BORROW,
//     OVF, internal shift registers, borrow FF and bit counter all go to 0. This holds mid-operation too:
//     the in-flight op is discarded and no DONE is issued.
//   - States: IDLE -> SHIFT -> FINISH -> IDLE.
//   - IDLE: if START=1 at an edge, latch A, B into shift regs, clear borrow FF and counter, go to SHIFT.
//     Otherwise stay. DIFF, BORROW and OVF keep their previous values.
//   - SHIFT: every edge, compute d = a0^b0^bin and bout = (~a0&b0) | (~(a0^b0)&bin) from the LSB of
//     each shift reg. Shift d into the result reg from the MSB side and shift the operand regs right.
//     bin <= bout. Counter increments.
//     After the WIDTH-th SHIFT edge (counter = WIDTH-1 on that edge), go to FINISH.
//   - FINISH: one cycle. DONE=1; DIFF = result reg; BORROW = borrow FF; OVF = (Amsb^Bmsb)&(Amsb^DIFFmsb),
//     using the latched operand MSBs. Next edge -> IDLE.
//   - Latency: START accepted at edge k; BUSY high during cycles k+1..k+WIDTH; DONE high in the cycle
//     after edge k+WIDTH. Total WIDTH+1 cycles from acceptance to DONE.
//   - Throughput: a new START is accepted only in IDLE. START in SHIFT or FINISH is ignored (not queued).
//     START held continuously gives one op every WIDTH+2 cycles.
//   - A and B may change freely after the accepting edge; only the latched copies are used.
//   - DIFF, BORROW and OVF are registered outputs and update only when entering FINISH.
//   - BUSY and DONE are never high together.
//   - Arithmetic: unsigned wrap modulo 2^WIDTH. B > A gives BORROW=1.
// STRUCTURE
//   - Shared package/header: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_FINISH=2'd2.
//     The counter width is defined there as $clog2(WIDTH).
//   - Sub-module half_subtractor (ports A, B, DIFF, BORROW: DIFF=A^B, BORROW=~A&B), combinational.
//     Instantiate it twice; OR the two borrows to form bout. Everything else stays in the top.
// TESTING (WIDTH=8)
//   1. A=8'h35, B=8'h12, START 1 cycle -> DONE in the 9th cycle after the accepting edge;
//      DIFF=8'h23, BORROW=0, OVF=0; BUSY high for exactly 8 cycles.
//   2. A=8'h12, B=8'h35 -> DIFF=8'hDD, BORROW=1, OVF=0.
//   3. A=8'h80, B=8'h01 -> DIFF=8'h7F, BORROW=0, OVF=1.
//      A=8'h00, B=8'h01 -> DIFF=8'hFF, BORROW=1, OVF=0.
//   4. Pulse START again during SHIFT with A=8'hFF, B=8'hFF -> ignored; only the first op's DONE occurs;
//      a later START in IDLE with the same operands gives DIFF=8'h00, BORROW=0.
//   5. RST=1 on the 4th SHIFT cycle -> next cycle all outputs 0 and state IDLE; no DONE pulse.
//      A fresh op then completes correctly.
//   6. START held high with random operands for 200 ops -> DONE every 10 cycles;
//      DIFF, BORROW and OVF match a reference model on every op.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and counter sizing.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Bit counter width; it only has to reach WIDTH-1.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Combinational half-subtractor cell; two of these plus a borrow FF make a full subtractor.
module half_subtractor (
    input  logic A,
    input  logic B,
    output logic DIFF,
    output logic BORROW
);

    assign DIFF   = A ^ B;
    assign BORROW = ~A & B;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock, with START/BUSY/DONE handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW,
    output logic             OVF
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] res;
    logic [CW-1:0]    cnt;
    logic             bin, amsb, bmsb;

    logic             d0, br0, d, br1, bout;
    logic [WIDTH-1:0] shf;

    half_subtractor u_hs0 (.A(a_sr[0]), .B(b_sr[0]), .DIFF(d0), .BORROW(br0));
    half_subtractor u_hs1 (.A(d0),      .B(bin),     .DIFF(d),  .BORROW(br1));

    assign bout = br0 | br1;
    // res keeps only the WIDTH-1 lower bits; the final bit arrives on the last edge
    // and goes straight into DIFF together with them.
    assign shf  = {d, res};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res    <= '0;
            cnt    <= '0;
            bin    <= 1'b0;
            amsb   <= 1'b0;
            bmsb   <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            DIFF   <= '0;
            BORROW <= 1'b0;
            OVF    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        amsb  <= A[WIDTH-1];
                        bmsb  <= B[WIDTH-1];
                        bin   <= 1'b0;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    res  <= shf[WIDTH-1:1];
                    bin  <= bout;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        DIFF   <= shf;
                        BORROW <= bout;
                        OVF    <= (amsb ^ bmsb) & (amsb ^ d);
                        state  <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    DONE  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and streaming checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [7:0] A = '0, B = '0;
    logic       BUSY, DONE, BORROW, OVF;
    logic [7:0] DIFF;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .DIFF(DIFF), .BORROW(BORROW), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Pulse START for one cycle, then watch until DONE; returns cycle of DONE and BUSY count.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int done_cyc, output int busy_cnt);
        done_cyc = 0;
        busy_cnt = 0;
        A = a; B = b; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        A = ~a; B = ~b;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (BUSY) busy_cnt++;
            if (BUSY && DONE) chk("busy_done_overlap", 1, 0);
            if (DONE) begin
                done_cyc = cyc;
                break;
            end
            @(negedge CLK);
        end
        if (done_cyc == 0) chk("done_timeout", 0, 1);
    endtask

    vec_t vecs[4];
    int   dc, bc, ndone;
    logic [7:0] ca, cb, ed;
    logic       eb, eo;

    initial begin
        vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0};
        vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};

        repeat (3) @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_diff", DIFF, 0);
        chk("rst_borrow", BORROW, 0);
        chk("rst_ovf", OVF, 0);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].a, vecs[i].b, dc, bc);
            chk($sformatf("v%0d_latency", i), dc, 9);
            chk($sformatf("v%0d_busy", i), bc, 8);
            chk($sformatf("v%0d_diff", i), DIFF, vecs[i].diff);
            chk($sformatf("v%0d_borrow", i), BORROW, vecs[i].borrow);
            chk($sformatf("v%0d_ovf", i), OVF, vecs[i].ovf);
            @(negedge CLK);
            chk($sformatf("v%0d_done_pulse", i), DONE, 0);
            chk($sformatf("v%0d_hold", i), DIFF, vecs[i].diff);
        end

        // START during SHIFT is ignored
        A = 8'h35; B = 8'h12; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        A = 8'hFF; B = 8'hFF; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            if (DONE) begin
                ndone++;
                chk("ign_diff", DIFF, 8'h23);
                chk("ign_borrow", BORROW, 0);
            end
            @(negedge CLK);
        end
        chk("ign_one_done", ndone, 1);
        run_op(8'hFF, 8'hFF, dc, bc);
        chk("ff_latency", dc, 9);
        chk("ff_diff", DIFF, 8'h00);
        chk("ff_borrow", BORROW, 0);
        chk("ff_ovf", OVF, 0);
        @(negedge CLK);

        // Reset on the 4th SHIFT cycle discards the op
        A = 8'h12; B = 8'h35; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("mrst_busy", BUSY, 0);
        chk("mrst_done", DONE, 0);
        chk("mrst_diff", DIFF, 0);
        chk("mrst_borrow", BORROW, 0);
        chk("mrst_ovf", OVF, 0);
        ndone = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (DONE || BUSY) ndone++;
            @(negedge CLK);
        end
        chk("mrst_quiet", ndone, 0);
        run_op(8'h80, 8'h01, dc, bc);
        chk("post_rst_latency", dc, 9);
        chk("post_rst_diff", DIFF, 8'h7F);
        chk("post_rst_ovf", OVF, 1);
        @(negedge CLK);
        @(negedge CLK);

        // START held high: one op every 10 cycles
        ca = 8'($urandom); cb = 8'($urandom);
        A = ca; B = cb; START = 1'b1;
        @(negedge CLK);
        for (int op = 0; op < 200; op++) begin
            dc = 0;
            for (int cyc = 1; cyc <= 12; cyc++) begin
                if (DONE) begin
                    dc = cyc;
                    break;
                end
                @(negedge CLK);
            end
            if (dc == 0) begin
                chk("stream_timeout", 0, 1);
                break;
            end
            if (op > 0) chk("stream_period", dc, 10);
            else        chk("stream_first", dc, 9);
            ed = ca - cb;
            eb = (ca < cb);
            eo = (ca[7] != cb[7]) && (ed[7] != ca[7]);
            if (DIFF !== ed || BORROW !== eb || OVF !== eo) begin
                bad++;
                $display("FAIL stream_op%0d: a=%h b=%h got diff=%h bor=%b ovf=%b want diff=%h bor=%b ovf=%b",
                         op, ca, cb, DIFF, BORROW, OVF, ed, eb, eo);
            end
            total++;
            ca = 8'($urandom); cb = 8'($urandom);
            A = ca; B = cb;
            @(negedge CLK);
        end
        START = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
